// File: rtl/dtree_pkg.sv
// Shared sizes, sequencer state encoding and width helper for the decision-tree
// feature loader.
package dtree_pkg;
   localparam int NUM_FEATURES = 5;
   localparam int FEAT_W       = 8;
   localparam int CLASS_W      = 1;

   typedef enum logic [1:0] {LOAD, SETTLE, RESULT} seq_state_t;

   // Width needed to index n items; never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/dtree_feature_sequencer.sv
// Assembles a byte stream into a frozen feature vector for the combinational
// tree, waits for the slow logic to settle, then offers the class on valid/ready.
module dtree_feature_sequencer
   import dtree_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [FEAT_W-1:0]              in_data,
   input  logic                           in_last,
   output logic [NUM_FEATURES*FEAT_W-1:0] feat_vec,
   input  logic [CLASS_W-1:0]             tree_out,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [CLASS_W-1:0]             res_class,
   output logic                           frame_err
);
   localparam int IDX_W = idx_w(NUM_FEATURES);
   localparam int CNT_W = idx_w(SETTLE_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEATURES - 1);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(SETTLE_CYCLES - 1);

   seq_state_t       state, state_d;
   logic [IDX_W-1:0] idx, idx_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             wr_en, err_d, res_valid_d, cap;

   // Decoded from state alone so res_ready never reaches in_ready combinationally.
   assign in_ready = (state == LOAD);

   always_comb begin
      state_d     = state;
      idx_d       = idx;
      cnt_d       = cnt;
      wr_en       = 1'b0;
      err_d       = 1'b0;
      res_valid_d = res_valid;
      cap         = 1'b0;
      case (state)
         LOAD: begin
            if (in_valid) begin
               wr_en = 1'b1;
               if (idx == LAST_IDX) begin
                  idx_d = '0;
                  if (in_last) begin
                     state_d = SETTLE;
                     cnt_d   = CNT_START;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (in_last) begin
                  idx_d = '0;
                  err_d = 1'b1;
               end else begin
                  idx_d = idx + 1'b1;
               end
            end
         end
         SETTLE: begin
            if (cnt != '0) begin
               cnt_d = cnt - 1'b1;
            end else begin
               cap         = 1'b1;
               res_valid_d = 1'b1;
               state_d     = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= LOAD;
         idx       <= '0;
         cnt       <= '0;
         feat_vec  <= '0;
         res_valid <= 1'b0;
         res_class <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_d;
         idx       <= idx_d;
         cnt       <= cnt_d;
         res_valid <= res_valid_d;
         frame_err <= err_d;
         // Short frames leave stale bytes in place; only the written slot changes.
         if (wr_en) feat_vec[idx*FEAT_W +: FEAT_W] <= in_data;
         if (cap)   res_class <= tree_out;
      end
   end
endmodule

// File: tb/tb_dtree_feature_sequencer.sv
// Directed + randomized bench for dtree_feature_sequencer with a stand-in tree.
module tb_dtree_feature_sequencer;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_last;
   logic [7:0]  in_data;
   logic [39:0] feat_vec;
   logic [0:0]  tree_out;
   logic        res_valid, res_ready, frame_err;
   logic [0:0]  res_class;

   int checks = 0;
   int errors = 0;

   logic [7:0] mfeat [5];
   int         midx;

   always #5 clk = ~clk;

   dtree_feature_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .feat_vec(feat_vec),
      .tree_out(tree_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_class(res_class), .frame_err(frame_err)
   );

   function automatic logic tree_fn(input logic [7:0] x0, x1, x2, x3, x4);
      logic [8:0] s;
      s = {1'b0, x0} + {1'b0, x1};
      return ((s > {1'b0, x2}) ^ (x4 < 8'h30)) | (x3 == 8'hFF);
   endfunction

   // Stand-in for the printed tree, driven straight from the DUT vector.
   always_comb tree_out = tree_fn(feat_vec[7:0], feat_vec[15:8], feat_vec[23:16],
                                  feat_vec[31:24], feat_vec[39:32]);

   function automatic logic [39:0] mvec();
      return {mfeat[4], mfeat[3], mfeat[2], mfeat[1], mfeat[0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 5; k++) mfeat[k] = 8'h00;
      midx = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit last, input bit gaps);
      bit err;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            step();
            chk("gap_frame_err", frame_err, 0);
            chk("gap_feat_hold", feat_vec, mvec());
         end
      end
      in_valid = 1'b1; in_data = d; in_last = last;
      chk("in_ready_load", in_ready, 1);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      mfeat[midx] = d;
      err = 1'b0;
      if (midx == 4) begin
         err  = !last;
         midx = 0;
      end else if (last) begin
         err  = 1'b1;
         midx = 0;
      end else begin
         midx++;
      end
      chk("feat_vec", feat_vec, mvec());
      chk("frame_err", frame_err, err);
   endtask

   task automatic send_frame(input logic [7:0] b [5], input bit gaps);
      for (int k = 0; k < 5; k++) send_byte(b[k], k == 4, gaps);
   endtask

   task automatic expect_result();
      for (int i = 0; i < S - 1; i++) begin
         step();
         chk("settle_no_valid", res_valid, 0);
         chk("settle_in_ready", in_ready, 0);
      end
      step();
      chk("res_valid", res_valid, 1);
      chk("res_class", res_class, tree_fn(mfeat[0], mfeat[1], mfeat[2], mfeat[3], mfeat[4]));
      chk("result_in_ready", in_ready, 0);
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("release_valid", res_valid, 0);
      chk("release_in_ready", in_ready, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_feat"}, feat_vec, 0);
      chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_class"}, res_class, 0);
      chk({tag, "_err"}, frame_err, 0);
      chk({tag, "_ready"}, in_ready, 1);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_reset_vals(tag);
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] fr [5];
      logic [39:0] held_vec;
      logic [0:0]  held_cls;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
      model_reset();
      step(); step();
      check_reset_vals("reset");
      rst = 1'b0;
      step();
      chk("post_reset_ready", in_ready, 1);

      // All-zero frame, no gaps.
      fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(fr, 1'b0);
      expect_result();
      release_result();

      // Ascending frame with random valid gaps.
      fr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      send_frame(fr, 1'b1);
      chk("vec_5040302010", feat_vec, 40'h5040302010);
      expect_result();
      release_result();

      // Short frame: error on the 3rd byte, then a clean frame from idx 0.
      send_byte(8'hA1, 1'b0, 1'b0);
      send_byte(8'hA2, 1'b0, 1'b0);
      send_byte(8'hA3, 1'b1, 1'b0);
      step();
      chk("short_err_one_cycle", frame_err, 0);
      chk("short_no_result", res_valid, 0);
      fr = '{8'h05, 8'h07, 8'h20, 8'h11, 8'h90};
      send_frame(fr, 1'b1);
      expect_result();
      release_result();

      // Long frame: 5th byte unterminated, 6th lands in feature 0.
      for (int k = 0; k < 5; k++) send_byte(8'hC0 + 8'(k), 1'b0, 1'b0);
      chk("long_no_result", res_valid, 0);
      send_byte(8'h77, 1'b0, 1'b0);
      chk("long_byte6_feat0", feat_vec[7:0], 8'h77);
      for (int k = 1; k < 5; k++) send_byte(8'h01 + 8'(k), k == 4, 1'b0);
      expect_result();
      release_result();

      // Back-to-back framing errors give back-to-back pulses.
      send_byte(8'h33, 1'b1, 1'b0);
      send_byte(8'h44, 1'b1, 1'b0);

      // Consumer stall: result and vector stay put, input ignored.
      fr = '{8'hFE, 8'h02, 8'h03, 8'hFF, 8'h60};
      send_frame(fr, 1'b1);
      expect_result();
      held_vec = feat_vec;
      held_cls = res_class;
      in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_valid", res_valid, 1);
         chk("stall_class", res_class, held_cls);
         chk("stall_vec", feat_vec, held_vec);
         chk("stall_ready", in_ready, 0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_result();

      // Reset during SETTLE.
      fr = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
      send_frame(fr, 1'b0);
      async_reset("rst_settle");
      for (int i = 0; i < S + 2; i++) begin
         step();
         chk("rst_settle_no_result", res_valid, 0);
      end

      // Reset with a result pending.
      fr = '{8'h21, 8'h43, 8'h65, 8'h87, 8'h09};
      send_frame(fr, 1'b1);
      expect_result();
      async_reset("rst_result");
      step();
      chk("rst_result_gone", res_valid, 0);
      fr = '{8'hE0, 8'h10, 8'hF0, 8'h00, 8'h2F};
      send_frame(fr, 1'b1);
      expect_result();
      release_result();

      // Randomized frames, occasionally corrupted.
      for (int n = 0; n < 12; n++) begin
         int kind;
         kind = $urandom_range(0, 3);
         if (kind == 0) begin
            int len;
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) send_byte(8'($urandom), k == len - 1, 1'b1);
         end
         for (int k = 0; k < 5; k++) fr[k] = 8'($urandom);
         send_frame(fr, 1'b1);
         expect_result();
         repeat ($urandom_range(0, 3)) begin
            step();
            chk("rand_hold_valid", res_valid, 1);
         end
         release_result();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
